// File: rtl/ddrphy_dly_tap_ctrl.sv
// Dynamic delay-line tap sequencer for one DDR PHY IOD lane.
// Converts an absolute tap request into single MOVE steps (or a LOAD), each followed by a settle window.
module ddrphy_dly_tap_ctrl #(
    parameter int TAP_W         = 8,
    parameter int INIT_TAP      = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             fab_clk,
    input  logic             arst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic [TAP_W-1:0] req_target,
    output logic             done,
    output logic             done_oor,
    output logic             busy,
    output logic [TAP_W-1:0] cur_tap,
    output logic             delay_line_move,
    output logic             delay_line_direction,
    output logic             delay_line_load,
    input  logic             delay_line_out_of_range
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // LOAD   | one-cycle reload pulse to the IOD
    // MOVE   | one-cycle step pulse to the IOD
    // SETTLE | settle window; out-of-range sampled in its last cycle
    // FINISH | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_SETTLE,
        S_FINISH
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [TAP_W-1:0] target;
    logic             is_load;
    logic             oor_flag;
    logic             oor_hit;
    logic             accept;

    assign accept    = req_valid && (state == S_IDLE);
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done_oor  = oor_flag;

    always_comb begin
        state_nxt = state;
        oor_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_load)
                        state_nxt = S_LOAD;
                    else if (req_target != cur_tap)
                        state_nxt = S_MOVE;
                    else
                        state_nxt = S_FINISH;
                end
            end
            S_LOAD:   state_nxt = S_SETTLE;
            S_MOVE:   state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    if (is_load) begin
                        state_nxt = S_FINISH;
                    end else if (delay_line_out_of_range) begin
                        oor_hit   = 1'b1;
                        state_nxt = S_FINISH;
                    end else if (cur_tap == target) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_MOVE;
                    end
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state                <= S_IDLE;
            settle_cnt           <= '0;
            target               <= '0;
            is_load              <= 1'b0;
            oor_flag             <= 1'b0;
            cur_tap              <= TAP_INIT;
            delay_line_move      <= 1'b0;
            delay_line_load      <= 1'b0;
            delay_line_direction <= 1'b0;
            done                 <= 1'b0;
        end else begin
            state           <= state_nxt;
            // Pulses are registered from the next state so they line up with it
            delay_line_move <= (state_nxt == S_MOVE);
            delay_line_load <= (state_nxt == S_LOAD);
            done            <= (state_nxt == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        target  <= req_target;
                        is_load <= req_load;
                        if (!req_load && (req_target != cur_tap))
                            delay_line_direction <= (req_target > cur_tap);
                    end
                end
                S_LOAD: begin
                    cur_tap    <= TAP_INIT;
                    settle_cnt <= CNT_LAST;
                end
                S_MOVE: begin
                    cur_tap    <= delay_line_direction ? (cur_tap + TAP_ONE) : (cur_tap - TAP_ONE);
                    settle_cnt <= CNT_LAST;
                end
                S_SETTLE: begin
                    if (settle_cnt != '0)
                        settle_cnt <= settle_cnt - 1'b1;
                    if (oor_hit) begin
                        // The line saturated, so the last step never happened
                        cur_tap  <= delay_line_direction ? (cur_tap - TAP_ONE) : (cur_tap + TAP_ONE);
                        oor_flag <= 1'b1;
                    end
                end
                S_FINISH: oor_flag <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddrphy_dly_tap_ctrl.sv
// Directed bench for ddrphy_dly_tap_ctrl with INIT_TAP=1, SETTLE_CYCLES=4.
// Cycle 1 is the cycle right after the accept edge; outputs are sampled 1 ns after each rising edge.
module tb_ddrphy_dly_tap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_load;
    logic [7:0] req_target;
    logic       done;
    logic       done_oor;
    logic       busy;
    logic [7:0] cur_tap;
    logic       mv;
    logic       dir;
    logic       ld;
    logic       oor_in;

    int checks   = 0;
    int failures = 0;

    int          moves, loads, done_cyc;
    logic [63:0] move_mask, load_mask;
    logic        got_oor, ready_bad, busy_bad, pulse_bad, dir_bad, aborted, idle_bad;

    ddrphy_dly_tap_ctrl #(.TAP_W(8), .INIT_TAP(1), .SETTLE_CYCLES(4)) dut (
        .fab_clk                 (clk),
        .arst_n                  (rst_n),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_load                (req_load),
        .req_target              (req_target),
        .done                    (done),
        .done_oor                (done_oor),
        .busy                    (busy),
        .cur_tap                 (cur_tap),
        .delay_line_move         (mv),
        .delay_line_direction    (dir),
        .delay_line_load         (ld),
        .delay_line_out_of_range (oor_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic load, input logic [7:0] tgt, input bit hold);
        req_load   = load;
        req_target = tgt;
        req_valid  = 1'b1;
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    // Watches one request from cycle 1 until DONE, then steps into the following idle cycle.
    task automatic observe(input logic exp_dir, input int oor_cyc, input int abort_cyc);
        bit prev_pulse;
        moves = 0; loads = 0; done_cyc = -1;
        move_mask = '0; load_mask = '0;
        got_oor = 1'b0; ready_bad = 1'b0; busy_bad = 1'b0;
        pulse_bad = 1'b0; dir_bad = 1'b0; aborted = 1'b0;
        prev_pulse = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (mv === 1'b1) begin
                moves++;
                if (c < 64) move_mask[c[5:0]] = 1'b1;
                if (dir !== exp_dir) dir_bad = 1'b1;
            end
            if (ld === 1'b1) begin
                loads++;
                if (c < 64) load_mask[c[5:0]] = 1'b1;
            end
            if ((mv === 1'b1) && (ld === 1'b1)) pulse_bad = 1'b1;
            if (((mv === 1'b1) || (ld === 1'b1)) && prev_pulse) pulse_bad = 1'b1;
            prev_pulse = (mv === 1'b1) || (ld === 1'b1);
            if (req_ready !== 1'b0) ready_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cyc = c;
                got_oor  = done_oor;
                break;
            end
            if (c == abort_cyc) begin
                aborted = 1'b1;
                return;
            end
            oor_in = (c == oor_cyc);
            tick();
        end
        oor_in = 1'b0;
        tick();
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
        chk({tag, "_busy_high"}, 64'(busy_bad), 64'd0);
        chk({tag, "_pulse_rules"}, 64'(pulse_bad), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_target = 8'd0;
        oor_in     = 1'b0;
        #22;
        rst_n = 1'b1;
        #1;
        chk("rst_cur_tap", 64'(cur_tap), 64'd1);
        chk("rst_outputs", 64'({mv, ld, dir, done, done_oor, busy, req_ready}), 64'h01);

        idle_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ((mv !== 1'b0) || (ld !== 1'b0) || (done !== 1'b0) || (busy !== 1'b0)) idle_bad = 1'b1;
        end
        chk("idle_50_quiet", 64'(idle_bad), 64'd0);

        // 1 -> 4
        issue(1'b0, 8'd4, 1'b0);
        observe(1'b1, 0, 0);
        chk("up4_moves", 64'(moves), 64'd3);
        chk("up4_move_cycles", move_mask, 64'h842);
        chk("up4_done_cycle", 64'(done_cyc), 64'd16);
        chk("up4_done_oor", 64'(got_oor), 64'd0);
        chk("up4_cur_tap", 64'(cur_tap), 64'd4);
        chk("up4_dir", 64'(dir_bad), 64'd0);
        chk_flags("up4");
        chk("up4_dir_hold_idle", 64'(dir), 64'd1);

        // 4 -> 0
        issue(1'b0, 8'd0, 1'b0);
        observe(1'b0, 0, 0);
        chk("dn0_moves", 64'(moves), 64'd4);
        chk("dn0_move_cycles", move_mask, 64'h10842);
        chk("dn0_done_cycle", 64'(done_cyc), 64'd21);
        chk("dn0_cur_tap", 64'(cur_tap), 64'd0);
        chk("dn0_dir", 64'(dir_bad), 64'd0);
        chk_flags("dn0");

        // target equals current tap
        issue(1'b0, 8'd0, 1'b0);
        observe(1'b0, 0, 0);
        chk("zero_done_cycle", 64'(done_cyc), 64'd1);
        chk("zero_moves", 64'(moves), 64'd0);
        chk("zero_cur_tap", 64'(cur_tap), 64'd0);

        // 0 -> 9, then LOAD
        issue(1'b0, 8'd9, 1'b0);
        observe(1'b1, 0, 0);
        chk("up9_moves", 64'(moves), 64'd9);
        chk("up9_done_cycle", 64'(done_cyc), 64'd46);
        chk("up9_cur_tap", 64'(cur_tap), 64'd9);

        issue(1'b1, 8'd200, 1'b0);
        observe(1'b1, 0, 0);
        chk("load_cycles", load_mask, 64'h2);
        chk("load_moves", 64'(moves), 64'd0);
        chk("load_done_cycle", 64'(done_cyc), 64'd6);
        chk("load_cur_tap", 64'(cur_tap), 64'd1);
        chk_flags("load");

        // 1 -> 7 with saturation flagged at the end of step 2
        issue(1'b0, 8'd7, 1'b0);
        observe(1'b1, 10, 0);
        chk("oor_moves", 64'(moves), 64'd2);
        chk("oor_move_cycles", move_mask, 64'h42);
        chk("oor_done_cycle", 64'(done_cyc), 64'd11);
        chk("oor_done_oor", 64'(got_oor), 64'd1);
        chk("oor_cur_tap", 64'(cur_tap), 64'd2);
        chk("oor_flag_cleared", 64'({done, done_oor}), 64'd0);

        issue(1'b1, 8'd0, 1'b0);
        observe(1'b1, 0, 0);
        chk("reload_cur_tap", 64'(cur_tap), 64'd1);

        // REQ_VALID held through a busy request; the target changed while busy must be ignored
        issue(1'b0, 8'd2, 1'b1);
        req_target = 8'd3;
        observe(1'b1, 0, 0);
        chk("hold_first_moves", 64'(moves), 64'd1);
        chk("hold_first_done", 64'(done_cyc), 64'd6);
        chk("hold_first_cur_tap", 64'(cur_tap), 64'd2);
        chk("hold_idle_after_done", 64'({req_ready, busy}), 64'h2);
        tick();
        chk("hold_second_accept", 64'({busy, mv, dir}), 64'h7);
        req_valid = 1'b0;
        observe(1'b1, 0, 0);
        chk("hold_second_done", 64'(done_cyc), 64'd6);
        chk("hold_second_cur_tap", 64'(cur_tap), 64'd3);

        issue(1'b1, 8'd0, 1'b0);
        observe(1'b1, 0, 0);

        // reset asserted during the MOVE pulse of step 2
        issue(1'b0, 8'd5, 1'b0);
        observe(1'b1, 0, 6);
        chk("rstmv_aborted", 64'(aborted), 64'd1);
        chk("rstmv_pre", 64'({mv, busy}), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmv_outputs", 64'({mv, ld, dir, done, done_oor, busy, req_ready}), 64'h01);
        chk("rstmv_cur_tap", 64'(cur_tap), 64'd1);
        #10 rst_n = 1'b1;
        tick();

        // reset asserted during the SETTLE of step 2
        issue(1'b0, 8'd5, 1'b0);
        observe(1'b1, 0, 8);
        chk("rstst_pre_cur_tap", 64'(cur_tap), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rstst_outputs", 64'({mv, ld, dir, done, done_oor, busy, req_ready}), 64'h01);
        chk("rstst_cur_tap", 64'(cur_tap), 64'd1);
        #10 rst_n = 1'b1;
        tick();

        issue(1'b0, 8'd3, 1'b0);
        observe(1'b1, 0, 0);
        chk("post_rst_moves", 64'(move_mask), 64'h42);
        chk("post_rst_done", 64'(done_cyc), 64'd11);
        chk("post_rst_cur_tap", 64'(cur_tap), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
